// File: rtl/pong_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : pong_game_fsm
//  Purpose  : Pong game sequencer. It detects missed returns from the ball and
//             paddle positions, keeps both scores, holds the ball for a serve
//             delay after each point and handles game over / restart.
//  Revision : 1.0  initial release
// ============================================================================
module pong_game_fsm #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int PADDLE_HEIGHT = 6,
    parameter int SCORE_LIMIT   = 9,
    parameter int SERVE_DELAY   = 25000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       Start_i,
    input  logic [5:0] Ball_X_i,
    input  logic [5:0] Ball_Y_i,
    input  logic [5:0] Paddle_Y_P1_i,
    input  logic [5:0] Paddle_Y_P2_i,
    output logic       Game_Active_o,
    output logic [3:0] P1_Score_o,
    output logic [3:0] P2_Score_o,
    output logic       Game_Over_o,
    output logic       Winner_o,
    output logic [1:0] State_o
);

    localparam logic [1:0]  c_IDLE       = 2'd0;
    localparam logic [1:0]  c_RUNNING    = 2'd1;
    localparam logic [1:0]  c_POINT      = 2'd2;
    localparam logic [1:0]  c_GAME_OVER  = 2'd3;

    localparam logic [5:0]  c_RIGHT_COL  = 6'(GAME_WIDTH - 1);
    localparam logic [6:0]  c_PAD_SPAN   = 7'(PADDLE_HEIGHT - 1);
    localparam logic [3:0]  c_LIMIT      = 4'(SCORE_LIMIT);
    localparam logic [31:0] c_SERVE_LAST = 32'(SERVE_DELAY - 1);

    // Reject parameter sets the 6-bit coordinates and 4-bit scores cannot hold.
    generate
        if (GAME_WIDTH < 2 || GAME_WIDTH > 64 || GAME_HEIGHT < 1 || GAME_HEIGHT > 64 ||
            PADDLE_HEIGHT < 1 || SCORE_LIMIT < 1 || SCORE_LIMIT > 15 || SERVE_DELAY < 1) begin : g_param_check
            $error("pong_game_fsm: parameter out of range");
        end
    endgenerate

    logic [1:0]  state_q,  state_d;
    logic [3:0]  p1_score_q, p1_score_d;
    logic [3:0]  p2_score_q, p2_score_d;
    logic [31:0] delay_cnt_q, delay_cnt_d;
    logic        winner_q, winner_d;
    logic        start_q;
    logic        game_active_q;
    logic        game_over_q;

    logic        w_start_press;
    logic [6:0]  w_p1_bottom;
    logic [6:0]  w_p2_bottom;
    logic        w_p1_miss;
    logic        w_p2_miss;
    logic [3:0]  w_p1_inc;
    logic [3:0]  w_p2_inc;

    // Rising edge of the start button; holding it down yields a single press.
    assign w_start_press = Start_i & ~start_q;

    // Paddle bottom rows are formed at 7 bits so a paddle near row 63 cannot wrap.
    assign w_p1_bottom = {1'b0, Paddle_Y_P1_i} + c_PAD_SPAN;
    assign w_p2_bottom = {1'b0, Paddle_Y_P2_i} + c_PAD_SPAN;

    assign w_p1_miss = (Ball_X_i == 6'd0) &&
                       ((Ball_Y_i < Paddle_Y_P1_i) || ({1'b0, Ball_Y_i} > w_p1_bottom));
    assign w_p2_miss = (Ball_X_i == c_RIGHT_COL) &&
                       ((Ball_Y_i < Paddle_Y_P2_i) || ({1'b0, Ball_Y_i} > w_p2_bottom));

    assign w_p1_inc = p1_score_q + 4'd1;
    assign w_p2_inc = p2_score_q + 4'd1;

    // Next-state and scoring logic; a P1 miss takes priority over a P2 miss.
    always_comb begin
        state_d     = state_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        delay_cnt_d = delay_cnt_q;
        winner_d    = winner_q;
        case (state_q)
            c_IDLE: begin
                if (w_start_press) begin
                    state_d    = c_RUNNING;
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                end
            end
            c_RUNNING: begin
                if (w_p1_miss) begin
                    p2_score_d = w_p2_inc;
                    if (w_p2_inc == c_LIMIT) begin
                        state_d  = c_GAME_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d     = c_POINT;
                        delay_cnt_d = 32'd0;
                    end
                end else if (w_p2_miss) begin
                    p1_score_d = w_p1_inc;
                    if (w_p1_inc == c_LIMIT) begin
                        state_d  = c_GAME_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d     = c_POINT;
                        delay_cnt_d = 32'd0;
                    end
                end
            end
            c_POINT: begin
                // The counter stops at its final value when the serve resumes.
                if (delay_cnt_q == c_SERVE_LAST) begin
                    state_d = c_RUNNING;
                end else begin
                    delay_cnt_d = delay_cnt_q + 32'd1;
                end
            end
            c_GAME_OVER: begin
                if (w_start_press) begin
                    state_d    = c_RUNNING;
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                    winner_d   = 1'b0;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State, scores and flag outputs, all registered from the next-state values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= c_IDLE;
            p1_score_q    <= 4'd0;
            p2_score_q    <= 4'd0;
            delay_cnt_q   <= 32'd0;
            winner_q      <= 1'b0;
            start_q       <= 1'b0;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            delay_cnt_q   <= delay_cnt_d;
            winner_q      <= winner_d;
            start_q       <= Start_i;
            game_active_q <= (state_d == c_RUNNING);
            game_over_q   <= (state_d == c_GAME_OVER);
        end
    end

    assign Game_Active_o = game_active_q;
    assign Game_Over_o   = game_over_q;
    assign Winner_o      = winner_q;
    assign P1_Score_o    = p1_score_q;
    assign P2_Score_o    = p2_score_q;
    assign State_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_game_fsm
//  Purpose  : Self-checking bench for pong_game_fsm: a directed vector table,
//             hand-written multi-cycle sequences and a randomized phase
//             compared against an event-level game model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_game_fsm;

    localparam int W     = 40;
    localparam int PH    = 6;
    localparam int LIMIT = 9;
    localparam int SD    = 8;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       Start_i = 1'b0;
    logic [5:0] Ball_X_i = 6'd20;
    logic [5:0] Ball_Y_i = 6'd15;
    logic [5:0] Paddle_Y_P1_i = 6'd5;
    logic [5:0] Paddle_Y_P2_i = 6'd5;
    logic       Game_Active_o;
    logic [3:0] P1_Score_o;
    logic [3:0] P2_Score_o;
    logic       Game_Over_o;
    logic       Winner_o;
    logic [1:0] State_o;

    pong_game_fsm #(
        .GAME_WIDTH   (W),
        .GAME_HEIGHT  (30),
        .PADDLE_HEIGHT(PH),
        .SCORE_LIMIT  (LIMIT),
        .SERVE_DELAY  (SD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .Start_i      (Start_i),
        .Ball_X_i     (Ball_X_i),
        .Ball_Y_i     (Ball_Y_i),
        .Paddle_Y_P1_i(Paddle_Y_P1_i),
        .Paddle_Y_P2_i(Paddle_Y_P2_i),
        .Game_Active_o(Game_Active_o),
        .P1_Score_o   (P1_Score_o),
        .P2_Score_o   (P2_Score_o),
        .Game_Over_o  (Game_Over_o),
        .Winner_o     (Winner_o),
        .State_o      (State_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Game model: tracks the match as phases and a serve countdown.
    int m_phase;        // 0 idle, 1 rally, 2 waiting to serve, 3 match over
    int m_s1, m_s2, m_serve_left, m_winner;
    bit m_prev_start;

    function automatic bit missed(int bx, int col, int by, int pad);
        return (bx == col) && ((by < pad) || (by > pad + PH - 1));
    endfunction

    task automatic model_step();
        bit press, m1, m2;
        if (rst_i) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_serve_left = 0; m_winner = 0; m_prev_start = 0;
            return;
        end
        press = Start_i && !m_prev_start;
        m_prev_start = Start_i;
        m1 = missed(int'(Ball_X_i), 0, int'(Ball_Y_i), int'(Paddle_Y_P1_i));
        m2 = missed(int'(Ball_X_i), W - 1, int'(Ball_Y_i), int'(Paddle_Y_P2_i));
        if (m_phase == 0) begin
            if (press) begin m_phase = 1; m_s1 = 0; m_s2 = 0; end
        end else if (m_phase == 1) begin
            if (m1 || m2) begin
                if (m1) m_s2++; else m_s1++;
                if (m_s1 == LIMIT || m_s2 == LIMIT) begin
                    m_phase = 3; m_winner = (m_s2 == LIMIT) ? 1 : 0;
                end else begin
                    m_phase = 2; m_serve_left = SD;
                end
            end
        end else if (m_phase == 2) begin
            m_serve_left--;
            if (m_serve_left == 0) m_phase = 1;
        end else begin
            if (press) begin m_phase = 1; m_s1 = 0; m_s2 = 0; m_winner = 0; end
        end
    endtask

    // One clock edge; inputs are already stable, outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic rst, input logic st, input int bx, input int by,
                          input int p1, input int p2);
        rst_i = rst; Start_i = st;
        Ball_X_i = 6'(bx); Ball_Y_i = 6'(by);
        Paddle_Y_P1_i = 6'(p1); Paddle_Y_P2_i = 6'(p2);
    endtask

    typedef struct {
        logic rst; logic st; int bx; int by; int p1; int p2;
        int e_state; int e_s1; int e_s2; int e_act;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rst, logic st, int bx, int by, int p1, int p2,
                                int es, int e1, int e2, int ea);
        vec_t v;
        v.rst = rst; v.st = st; v.bx = bx; v.by = by; v.p1 = p1; v.p2 = p2;
        v.e_state = es; v.e_s1 = e1; v.e_s2 = e2; v.e_act = ea;
        tbl.push_back(v);
    endfunction

    initial begin
        // rst st  bx  by  p1  p2   state s1 s2 act
        add(1, 0, 20, 15,  5,  5,   0, 0, 0, 0);   // reset
        add(0, 1, 20, 15,  5,  5,   1, 0, 0, 1);   // start press
        for (int i = 0; i < 4; i++)
            add(0, 1, 20, 15,  5,  5,   1, 0, 0, 1);   // start held: no second press
        add(0, 0,  0, 10,  5,  5,   1, 0, 0, 1);   // hit at paddle bottom
        add(0, 0,  0,  5,  5,  5,   1, 0, 0, 1);   // hit at paddle top
        add(0, 0,  0, 11,  5,  5,   2, 0, 1, 0);   // one row below: miss
        for (int i = 0; i < SD - 1; i++)
            add(0, 0,  0, 11,  5,  5,   2, 0, 1, 0);   // serve delay, miss ignored
        add(0, 0, 20, 15,  5,  5,   1, 0, 1, 1);   // serve resumes after SD clocks
        add(0, 0, 39, 29,  5, 28,   1, 0, 1, 1);   // P2 paddle near bottom: hit, no wrap
        add(0, 0,  0, 20,  5,  5,   2, 0, 2, 0);   // far miss

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].st, tbl[i].bx, tbl[i].by, tbl[i].p1, tbl[i].p2);
            tick();
            chk($sformatf("vec%0d state", i), int'(State_o), tbl[i].e_state);
            chk($sformatf("vec%0d p1", i), int'(P1_Score_o), tbl[i].e_s1);
            chk($sformatf("vec%0d p2", i), int'(P2_Score_o), tbl[i].e_s2);
            chk($sformatf("vec%0d active", i), int'(Game_Active_o), tbl[i].e_act);
            if (i == 0) begin
                chk("reset over", int'(Game_Over_o), 0);
                chk("reset winner", int'(Winner_o), 0);
            end
        end

        // P1 wins a full match through P2 misses, then restarts.
        set_in(1, 0, 20, 15, 5, 20); tick();
        set_in(0, 1, 20, 15, 5, 20); tick();
        Start_i = 1'b0;
        for (int i = 0; i < LIMIT - 1; i++) begin
            Ball_X_i = 6'd39; Ball_Y_i = 6'd0; tick();
            chk($sformatf("rally%0d p1", i), int'(P1_Score_o), i + 1);
            chk($sformatf("rally%0d state", i), int'(State_o), 2);
            Ball_X_i = 6'd20; Ball_Y_i = 6'd15;
            repeat (SD) tick();
            chk($sformatf("rally%0d serve", i), int'(State_o), 1);
        end
        Ball_X_i = 6'd39; Ball_Y_i = 6'd0; tick();
        chk("win p1", int'(P1_Score_o), LIMIT);
        chk("win state", int'(State_o), 3);
        chk("win over", int'(Game_Over_o), 1);
        chk("win winner", int'(Winner_o), 0);
        chk("win active", int'(Game_Active_o), 0);
        Ball_X_i = 6'd20; Ball_Y_i = 6'd15;
        repeat (3) tick();
        chk("over frozen", int'(P1_Score_o), LIMIT);
        Start_i = 1'b1; tick();
        chk("restart state", int'(State_o), 1);
        chk("restart p1", int'(P1_Score_o), 0);
        chk("restart p2", int'(P2_Score_o), 0);
        chk("restart over", int'(Game_Over_o), 0);
        chk("restart active", int'(Game_Active_o), 1);
        Start_i = 1'b0; tick();

        // Reset in the middle of a serve delay.
        set_in(0, 0, 0, 20, 5, 20); tick();
        chk("pt state", int'(State_o), 2);
        Ball_X_i = 6'd20; Ball_Y_i = 6'd15;
        repeat (4) tick();
        chk("pt hold", int'(State_o), 2);
        rst_i = 1'b1; tick();
        chk("rst state", int'(State_o), 0);
        chk("rst p2", int'(P2_Score_o), 0);
        chk("rst active", int'(Game_Active_o), 0);
        chk("rst over", int'(Game_Over_o), 0);
        rst_i = 1'b0;

        // Randomized play against the model.
        for (int c = 0; c < 4000; c++) begin
            int sel;
            rst_i = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) Start_i = ~Start_i;
            sel = int'($urandom_range(0, 3));
            Ball_X_i = (sel == 0) ? 6'd0 : (sel == 1) ? 6'(W - 1) : 6'($urandom_range(0, 63));
            Ball_Y_i = 6'($urandom_range(0, 63));
            Paddle_Y_P1_i = 6'($urandom_range(0, 63));
            Paddle_Y_P2_i = 6'($urandom_range(0, 63));
            tick();
            chk("rnd state", int'(State_o), m_phase);
            chk("rnd p1", int'(P1_Score_o), m_s1);
            chk("rnd p2", int'(P2_Score_o), m_s2);
            chk("rnd active", int'(Game_Active_o), (m_phase == 1) ? 1 : 0);
            chk("rnd over", int'(Game_Over_o), (m_phase == 3) ? 1 : 0);
            chk("rnd winner", int'(Winner_o), m_winner);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
